interp_sequencer: RTL and testbench

- Sequences the interpolator.
- Fetches waveform samples from a synchronous waveform ROM and presents the pair out2 (current sample S[k]) and out1 (next sample S[k+1]).
- Issues a one-cycle Enable strobe every 10**Mode_out Fg_CLK cycles.
- Supplies the registered Mode_out that the interpolator uses as its divide exponent. Sits between the DDS control registers and the interpolator.

---
 rtl/dds_pkg.sv | 37 +++
 rtl/decade_counter.sv | 30 +++
 rtl/interp_sequencer.sv | 141 ++++++++++++++
 tb/tb_interp_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sequencing path: FSM states,
// decade period table and the mode clamp.
package dds_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL0,
      ST_FILL1,
      ST_FILL2,
      ST_RUN
   } state_t;

   localparam int MAX_MODE = 4;
   localparam int CNT_W    = 14;

   localparam logic [CNT_W-1:0] DECADE_N [4] = '{14'd10, 14'd100, 14'd1000, 14'd10000};

   // Mode 0 is promoted to 1 so every period is at least 10 cycles, leaving
   // room for the mid-period prefetch.
   function automatic logic [3:0] clamp_mode(input logic [3:0] mode, input logic [3:0] max_mode);
      if (mode == 4'd0)
         return 4'd1;
      if (mode > max_mode)
         return max_mode;
      return mode;
   endfunction

   function automatic logic [CNT_W-1:0] decade_last(input logic [3:0] mode);
      case (mode)
         4'd1:    return DECADE_N[0] - 14'd1;
         4'd2:    return DECADE_N[1] - 14'd1;
         4'd3:    return DECADE_N[2] - 14'd1;
         default: return DECADE_N[3] - 14'd1;
      endcase
   endfunction

endpackage

// File: rtl/decade_counter.sv
// Loadable period counter: counts 0..last and wraps, flags last and 2.
// Latency: flags are combinational from the registered count.
// Backpressure: none; advances whenever i_en is high.
module decade_counter
   import dds_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_last,
   output logic             o_tc,
   output logic             o_at2
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_count <= '0;
      else if (i_load)
         r_count <= i_last;
      else if (i_en)
         r_count <= o_tc ? '0 : r_count + CNT_W'(1);
   end

   assign o_tc  = (r_count == i_last);
   assign o_at2 = (r_count == CNT_W'(2));

endmodule

// File: rtl/interp_sequencer.sv
// Fetches ROM samples S[k], S[k+1] for the interpolator and strobes Enable every 10**Mode_out cycles.
// Latency: first Enable in the 5th cycle after Run is sampled; ROM read latency is one cycle.
// Backpressure: none; Run=0 stops at the next period boundary (or at once while filling).
module interp_sequencer
   import dds_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int MAX_MODE = dds_pkg::MAX_MODE
)(
   input  logic              Fg_CLK,
   input  logic              RESETn,
   input  logic              Run,
   input  logic [3:0]        Mode,
   input  logic [ADDR_W-1:0] Step,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic              Enable,
   output logic [3:0]        Mode_out,
   output logic              active
);

   state_t            r_state, w_state;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [DATA_W-1:0] r_out1, w_out1;
   logic [DATA_W-1:0] r_out2, w_out2;
   logic [DATA_W-1:0] r_nxt, w_nxt;
   logic              r_enable, w_enable;
   logic [3:0]        r_mode, w_mode;
   logic              w_cnt_load, w_cnt_en, w_tc, w_at2;
   logic [3:0]        w_mode_req;
   logic [CNT_W-1:0]  w_last;

   assign w_mode_req = clamp_mode(Mode, 4'(MAX_MODE));
   assign w_last     = decade_last(r_mode);

   decade_counter u_cnt (
      .i_clk   (Fg_CLK),
      .i_rst_n (RESETn),
      .i_load  (w_cnt_load),
      .i_en    (w_cnt_en),
      .i_last  (w_last),
      .o_tc    (w_tc),
      .o_at2   (w_at2)
   );

   always_ff @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_state  <= ST_IDLE;
         r_addr   <= '0;
         r_out1   <= '0;
         r_out2   <= '0;
         r_nxt    <= '0;
         r_enable <= 1'b0;
         r_mode   <= 4'd1;
      end else begin
         r_state  <= w_state;
         r_addr   <= w_addr;
         r_out1   <= w_out1;
         r_out2   <= w_out2;
         r_nxt    <= w_nxt;
         r_enable <= w_enable;
         r_mode   <= w_mode;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_addr     = r_addr;
      w_out1     = r_out1;
      w_out2     = r_out2;
      w_nxt      = r_nxt;
      w_enable   = 1'b0;
      w_mode     = r_mode;
      w_cnt_load = 1'b0;
      w_cnt_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Run) begin
               w_state = ST_FILL0;
               w_addr  = '0;
               w_mode  = w_mode_req;
            end
         end
         ST_FILL0: begin
            if (!Run) begin
               w_state = ST_IDLE;
            end else begin
               w_state = ST_FILL1;
               w_addr  = Step;
            end
         end
         ST_FILL1: begin
            if (!Run) begin
               w_state = ST_IDLE;
            end else begin
               w_state = ST_FILL2;
               w_out1  = rom_data;
            end
         end
         ST_FILL2: begin
            if (!Run) begin
               w_state = ST_IDLE;
            end else begin
               w_state    = ST_RUN;
               w_nxt      = rom_data;
               w_addr     = Step + Step;
               w_cnt_load = 1'b1;
            end
         end
         ST_RUN: begin
            w_cnt_en = 1'b1;
            // Stopping copies out1 into out2 so the interpolator slope goes to zero.
            if (w_tc) begin
               w_out2 = r_out1;
               if (Run) begin
                  w_enable = 1'b1;
                  w_out1   = r_nxt;
                  w_mode   = w_mode_req;
               end else begin
                  w_state = ST_IDLE;
               end
            end else if (w_at2) begin
               w_nxt  = rom_data;
               w_addr = r_addr + Step;
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   assign rom_addr = r_addr;
   assign out1     = r_out1;
   assign out2     = r_out2;
   assign Enable   = r_enable;
   assign Mode_out = r_mode;
   assign active   = (r_state == ST_RUN);

endmodule

// File: tb/tb_interp_sequencer.sv
// Bench for interp_sequencer: event-time reference model plus directed literal checks.
module tb_interp_sequencer;

   logic        Fg_CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        Run    = 1'b0;
   logic [3:0]  Mode   = 4'd1;
   logic [9:0]  Step   = 10'd1;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] out1, out2;
   logic        Enable;
   logic [3:0]  Mode_out;
   logic        active;

   logic [31:0] rom [1024];
   int n_vec = 0;
   int n_bad = 0;

   interp_sequencer #(.ADDR_W(10), .DATA_W(32), .MAX_MODE(4)) dut (
      .Fg_CLK   (Fg_CLK),
      .RESETn   (RESETn),
      .Run      (Run),
      .Mode     (Mode),
      .Step     (Step),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .out1     (out1),
      .out2     (out2),
      .Enable   (Enable),
      .Mode_out (Mode_out),
      .active   (active)
   );

   always #5 Fg_CLK = ~Fg_CLK;

   always @(posedge Fg_CLK) rom_data <= rom[rom_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (absolute edge timestamps) ----------------
   int unsigned cyc;
   int unsigned m_t0, m_bd, m_k;
   int          m_phase;          // 0 idle, 1 filling, 2 running
   int unsigned m_mode;
   logic [31:0] m_out1, m_out2;
   logic        m_en, m_act;
   logic [9:0]  m_addr_exp;

   function automatic int unsigned clampm(input logic [3:0] m);
      if (m == 0) return 1;
      if (m > 4) return 4;
      return m;
   endfunction

   function automatic int unsigned pow10(input int unsigned e);
      int unsigned p = 1;
      for (int i = 0; i < int'(e); i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [31:0] samp(input int unsigned j);
      return rom[(j * int'(Step)) % 1024];
   endfunction

   always @(posedge Fg_CLK or negedge RESETn) begin
      if (!RESETn) begin
         cyc = 0; m_phase = 0; m_out1 = 0; m_out2 = 0; m_en = 0; m_act = 0;
         m_mode = 1; m_k = 0; m_t0 = 0; m_bd = 0; m_addr_exp = 0;
      end else begin
         cyc++;
         m_en = 0;
         if (m_phase == 0) begin
            if (Run) begin
               m_phase = 1; m_t0 = cyc; m_mode = clampm(Mode); m_k = 0;
            end
         end else if (m_phase == 1) begin
            if (!Run) m_phase = 0;
            else if (cyc == m_t0 + 2) m_out1 = samp(0);
            else if (cyc == m_t0 + 3) begin
               m_phase = 2; m_act = 1; m_bd = cyc + 1;
            end
         end else if (cyc == m_bd) begin
            if (Run) begin
               m_en = 1;
               m_out2 = samp(m_k);
               m_out1 = samp(m_k + 1);
               m_addr_exp = 10'(((m_k + 2) * int'(Step)) % 1024);
               m_k++;
               m_mode = clampm(Mode);
               m_bd = cyc + pow10(m_mode);
            end else begin
               m_out2 = m_out1; m_phase = 0; m_act = 0;
            end
         end
      end
   end

   always @(negedge Fg_CLK) begin
      if (RESETn) begin
         check("enable", Enable, m_en);
         check("mode_out", Mode_out, m_mode);
         check("active", active, m_act);
         check("out1", out1, m_out1);
         check("out2", out2, m_out2);
         if (m_en) check("rom_addr_at_enable", rom_addr, m_addr_exp);
      end
   end

   task automatic tick();
      @(posedge Fg_CLK);
      #1;
   endtask

   task automatic wait_stopped(input string name);
      int n = 0;
      while (active && n < 20000) begin tick(); n++; end
      check(name, active, 0);
      tick(); tick();
   endtask

   initial begin
      int n;
      for (int i = 0; i < 1024; i++) rom[i] = i << 12;
      repeat (3) @(negedge Fg_CLK);
      RESETn = 1'b1;
      @(negedge Fg_CLK);
      check("rst_addr", rom_addr, 0);
      check("rst_out1", out1, 0);
      check("rst_enable", Enable, 0);
      check("rst_mode_out", Mode_out, 1);
      check("rst_active", active, 0);

      // basic sequencing, Step=1, Mode=1
      Run = 1'b1;
      tick(); check("t2_addr0", rom_addr, 10'h000);
      tick(); check("t2_addr1", rom_addr, 10'h001);
      tick(); check("t2_out1_s0", out1, 32'h0);
      tick(); check("t2_addr2", rom_addr, 10'h002);
              check("t2_active", active, 1);
      tick(); check("t2_first_en", Enable, 1);
              check("t2_out2_a", out2, 32'h0000);
              check("t2_out1_a", out1, 32'h1000);
      repeat (9) @(posedge Fg_CLK);
      tick(); check("t2_en2", Enable, 1);
              check("t2_out1_b", out1, 32'h2000);
      repeat (9) @(posedge Fg_CLK);
      tick(); check("t2_en3", Enable, 1);
              check("t2_out1_c", out1, 32'h3000);

      // mode change mid-period only takes effect at the boundary
      repeat (3) @(posedge Fg_CLK);
      #2 Mode = 4'd2;
      repeat (7) @(posedge Fg_CLK);
      #1 check("t4_en_after10", Enable, 1);
      check("t4_mode2", Mode_out, 2);
      check("t4_out1", out1, 32'h4000);
      repeat (100) @(posedge Fg_CLK);
      #1 check("t4_en_after100", Enable, 1);
      check("t4_out1_b", out1, 32'h5000);

      // stop mid-period
      repeat (20) @(posedge Fg_CLK);
      #2 Run = 1'b0;
      repeat (80) @(posedge Fg_CLK);
      #1 check("t5_no_en", Enable, 0);
      check("t5_inactive", active, 0);
      check("t5_out2_hold", out2, 32'h5000);
      check("t5_out1_hold", out1, 32'h5000);

      // restart from address 0, Mode 0 clamps to 1
      Mode = 4'd0; Run = 1'b1;
      tick(); check("t5_restart_addr", rom_addr, 0);
      check("t3_mode0_clamp", Mode_out, 1);
      repeat (25) tick();
      Mode = 4'd9;
      n = 0;
      do begin tick(); n++; end while (!Enable && n < 12);
      check("t3_boundary", Enable, 1);
      check("t3_mode9_clamp", Mode_out, 4);
      n = 0;
      do begin tick(); n++; end while (!Enable && n < 10010);
      check("t3_period_10000", n, 10000);
      Run = 1'b0;
      wait_stopped("t3_stop");

      // address wrap with Step=0x3FF
      Step = 10'h3FF; Mode = 4'd1; Run = 1'b1;
      tick(); check("t6_addr0", rom_addr, 10'h000);
      tick(); check("t6_addr1", rom_addr, 10'h3FF);
      tick();
      tick(); check("t6_addr2", rom_addr, 10'h3FE);
      repeat (4) tick();
      check("t6_addr3", rom_addr, 10'h3FD);
      repeat (30) tick();
      Run = 1'b0;
      wait_stopped("t6_stop");

      // randomized episodes with random ROM, step, mode changes and stops
      for (int i = 0; i < 1024; i++) rom[i] = $urandom;
      for (int e = 0; e < 30; e++) begin
         int len;
         @(negedge Fg_CLK);
         Step = 10'($urandom_range(0, 1023));
         Mode = 4'($urandom_range(0, 2));
         Run  = 1'b1;
         len  = $urandom_range(0, 60);
         for (int c = 0; c < len; c++) begin
            @(negedge Fg_CLK);
            if ($urandom_range(0, 7) == 0) Mode = 4'($urandom_range(0, 2));
         end
         @(negedge Fg_CLK);
         Run  = 1'b0;
         Mode = 4'($urandom_range(0, 2));
         wait_stopped("rnd_stop");
      end

      // asynchronous reset in the middle of RUN
      Mode = 4'd2; Run = 1'b1;
      repeat (50) @(posedge Fg_CLK);
      #3 RESETn = 1'b0;
      #1;
      check("t1_addr", rom_addr, 0);
      check("t1_out1", out1, 0);
      check("t1_out2", out2, 0);
      check("t1_enable", Enable, 0);
      check("t1_mode_out", Mode_out, 1);
      check("t1_active", active, 0);
      @(negedge Fg_CLK);
      Run = 1'b0;
      RESETn = 1'b1;
      repeat (3) @(negedge Fg_CLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
